// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks the WM8731 register table, issuing one 24-bit I2C write per entry.
// Ports:
//   i_clk         50 MHz system clock
//   i_swt         asynchronous active-low reset
//   i_start       begin (re)configuration; only honoured in IDLE, DONE, ERROR
//   i_i2c_end     one-cycle completion pulse from the I2C byte engine
//   i_i2c_nack    valid with i_i2c_end; 1 = a byte was not acknowledged
//   o_i2c_data    {DEV_ADDR, reg[6:0], val[8:0]}, held from go until end
//   o_i2c_go      one-cycle write request
//   o_busy        high outside IDLE, DONE, ERROR
//   o_config_done table written successfully
//   o_config_err  an entry exhausted its retries
//   o_cur_index   table entry in progress (last attempted in ERROR)
module codec_config_sequencer #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         NUM_REGS    = 10,
    parameter int         MAX_RETRY   = 3,
    parameter int         PWRUP_CYC   = 50000,
    parameter int         GAP_CYC     = 2500,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic        i_clk,
    input  logic        i_swt,
    input  logic        i_start,
    input  logic        i_i2c_end,
    input  logic        i_i2c_nack,
    output logic [23:0] o_i2c_data,
    output logic        o_i2c_go,
    output logic        o_busy,
    output logic        o_config_done,
    output logic        o_config_err,
    output logic [3:0]  o_cur_index
);
    localparam int CNT_TOP = (PWRUP_CYC > TIMEOUT_CYC)
        ? ((PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC)
        : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_TOP);
    localparam logic [CW-1:0] PWRUP_END = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC - 1);
    // The ISSUE cycle counts toward the timeout, so WAIT gives up one cycle early.
    localparam logic [CW-1:0] WAIT_END  = CW'(TIMEOUT_CYC - 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);
    // {reg[6:0], val[8:0]}; entry 9 (activate) must stay last.
    localparam logic [15:0] TBL [16] = '{
        {7'd15, 9'h000}, {7'd0, 9'h017}, {7'd1, 9'h017}, {7'd2, 9'h079},
        {7'd3,  9'h079}, {7'd4, 9'h012}, {7'd5, 9'h000}, {7'd6, 9'h000},
        {7'd7,  9'h042}, {7'd9, 9'h001}, 16'h0, 16'h0,
        16'h0, 16'h0, 16'h0, 16'h0
    };

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_ISSUE, S_WAIT, S_RETRY, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_index, w_index;
    logic [RW-1:0]  r_retry, w_retry;
    logic           r_ok, w_ok;

    always_comb begin
        w_next  = r_state;
        w_index = r_index;
        w_retry = r_retry;
        w_ok    = r_ok;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (i_start) begin
                w_next  = S_PWRUP;
                w_index = '0;
                w_retry = '0;
                w_ok    = 1'b0;
            end
            S_PWRUP: w_next = (r_cnt == PWRUP_END) ? S_ISSUE : S_PWRUP;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: if (i_i2c_end && !i_i2c_nack) begin
                w_next  = S_GAP;
                w_retry = '0;
                w_ok    = 1'b1;
            end else if (i_i2c_end || r_cnt == WAIT_END) begin
                w_next  = S_RETRY;
            end
            S_RETRY: if (r_retry < RETRY_MAX) begin
                w_next  = S_GAP;
                w_retry = r_retry + 1'b1;
                w_ok    = 1'b0;
            end else begin
                w_next  = S_ERROR;
            end
            // A failed write re-issues the same index after the gap.
            S_GAP: if (r_cnt == GAP_END) begin
                w_next  = (r_ok && r_index == LAST_IDX) ? S_DONE : S_ISSUE;
                w_index = (r_ok && r_index != LAST_IDX) ? r_index + 4'd1 : r_index;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One shared counter: restarts on every state change, saturates otherwise.
    always_ff @(posedge i_clk or negedge i_swt) begin
        if (!i_swt) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_index <= '0;
            r_retry <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            r_index <= w_index;
            r_retry <= w_retry;
            r_ok    <= w_ok;
        end
    end

    assign o_i2c_go      = r_state == S_ISSUE;
    assign o_i2c_data    = (r_state == S_ISSUE || r_state == S_WAIT) ? {DEV_ADDR, TBL[r_index]} : 24'h0;
    assign o_busy        = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign o_config_done = r_state == S_DONE;
    assign o_config_err  = r_state == S_ERROR;
    assign o_cur_index   = r_index;
endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb_codec_config_sequencer: randomized I2C engine model and table-level reference for the sequencer.
module tb_codec_config_sequencer;
    localparam int P  = 40;
    localparam int G  = 20;
    localparam int T  = 150;
    localparam int MR = 3;
    localparam int NR = 10;

    logic        clk = 1'b0;
    logic        swt = 1'b0;
    logic        start = 1'b0;
    logic        i2c_end = 1'b0;
    logic        i2c_nack = 1'b0;
    logic [23:0] i2c_data;
    logic        i2c_go, busy, done, err;
    logic [3:0]  cur_index;

    codec_config_sequencer #(
        .DEV_ADDR(8'h34), .NUM_REGS(NR), .MAX_RETRY(MR),
        .PWRUP_CYC(P), .GAP_CYC(G), .TIMEOUT_CYC(T)
    ) dut (
        .i_clk(clk), .i_swt(swt), .i_start(start),
        .i_i2c_end(i2c_end), .i_i2c_nack(i2c_nack),
        .o_i2c_data(i2c_data), .o_i2c_go(i2c_go), .o_busy(busy),
        .o_config_done(done), .o_config_err(err), .o_cur_index(cur_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int reg_tab [NR] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 9};
    int val_tab [NR] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h042, 'h001};

    function automatic logic [23:0] exp_data(input int i);
        return 24'(32'h340000 + reg_tab[i] * 512 + val_tab[i]);
    endfunction

    // Engine model: plan[i] = NACKs before an ACK for entry i; silent_idx never answers.
    int          plan [NR];
    int          att  [NR];
    int          silent_idx = -1;
    bit          stray_req = 1'b0;
    int          pend_cnt = 0;
    bit          pend_nack = 1'b0;
    int          last_end = 0;
    bit          have_end = 1'b0;
    logic [23:0] go_q [$];
    int          gcyc_q [$];

    always @(negedge clk) begin
        int idx;
        i2c_end  = 1'b0;
        i2c_nack = 1'b0;
        if (stray_req) begin
            i2c_end   = 1'b1;
            stray_req = 1'b0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                i2c_end  = 1'b1;
                i2c_nack = pend_nack;
                last_end = cyc;
                have_end = 1'b1;
            end
        end
        if (i2c_go) begin
            check("serial", pend_cnt, 0);
            if (have_end) check("gap", 32'((cyc - last_end) >= G + 1), 1);
            have_end = 1'b0;
            go_q.push_back(i2c_data);
            gcyc_q.push_back(cyc);
            idx = -1;
            for (int i = 0; i < NR; i++) if (reg_tab[i] == int'(i2c_data[15:9])) idx = i;
            if (idx < 0) begin
                pend_nack = 1'b0;
                pend_cnt  = $urandom_range(5, 40);
            end else if (idx != silent_idx) begin
                pend_nack = att[idx] < plan[idx];
                att[idx]++;
                pend_cnt  = $urandom_range(5, 40);
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < NR; i++) plan[i] = 0;
        silent_idx = -1;
    endtask

    task automatic prep();
        go_q.delete();
        gcyc_q.delete();
        for (int i = 0; i < NR; i++) att[i] = 0;
        have_end = 1'b0;
    endtask

    // One full configuration, compared against the table walked at entry level.
    task automatic run_cfg(input bit poke);
        logic [23:0] exp_q [$];
        int s, k, n, stop;
        prep();
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 20000) begin
            @(negedge clk);
            if (!busy) break;
            start = poke && (k % 97 == 5);
            k++;
        end
        start = 1'b0;
        check("finish", 32'(k < 20000), 1);
        repeat (300) @(negedge clk);
        stop = -1;
        for (int i = 0; i < NR; i++) begin
            n = (i == silent_idx) ? 99 : plan[i];
            for (int r = 0; r < ((n > MR) ? MR + 1 : n + 1); r++) exp_q.push_back(exp_data(i));
            if (n > MR) begin
                stop = i;
                break;
            end
        end
        check("go_count", go_q.size(), exp_q.size());
        for (int j = 0; j < go_q.size() && j < exp_q.size(); j++) check("go_data", {8'h0, go_q[j]}, {8'h0, exp_q[j]});
        if (gcyc_q.size() > 0) check("latency", gcyc_q[0] - s, P + 1);
        check("done", 32'(done), 32'(stop < 0));
        check("err", 32'(err), 32'(stop >= 0));
        check("busy_end", 32'(busy), 0);
        if (stop >= 0) check("cur_index", 32'(cur_index), stop);
    endtask

    initial begin
        int c, k;
        clear_plan();
        for (int i = 0; i < NR; i++) att[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_go", 32'(i2c_go), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_idx", 32'(cur_index), 0);
        check("rst_data", {8'h0, i2c_data}, 0);
        swt = 1'b1;

        // i2c_end while idle
        stray_req = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_end_busy", 32'(busy), 0);
        check("idle_end_go", go_q.size(), 0);

        // clean run
        run_cfg(1'b0);
        if (go_q.size() == NR) begin
            check("data0", {8'h0, go_q[0]}, 32'h341E00);
            check("data9", {8'h0, go_q[9]}, 32'h341201);
        end else check("clean_len", go_q.size(), NR);

        // entry 3 NACKed twice
        plan[3] = 2;
        run_cfg(1'b0);
        c = 0;
        foreach (go_q[j]) if (go_q[j] == 24'h340479) c++;
        check("e3_sends", c, 3);

        // entry 5 always NACKed
        clear_plan();
        plan[5] = 99;
        run_cfg(1'b0);
        c = 0;
        foreach (go_q[j]) if (go_q[j] == exp_data(5)) c++;
        check("e5_sends", c, MR + 1);

        // entry 0 never answered
        clear_plan();
        silent_idx = 0;
        run_cfg(1'b0);
        for (int j = 1; j < gcyc_q.size(); j++) check("to_period", gcyc_q[j] - gcyc_q[j - 1], T + G + 1);
        clear_plan();

        // start pulses while busy (started from ERROR), then restart from DONE
        run_cfg(1'b1);
        run_cfg(1'b0);

        // randomized NACK plans
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NR; i++) begin
                c = $urandom_range(0, 19);
                plan[i] = (c < 12) ? 0 : (c < 15) ? 1 : (c < 17) ? 2 : (c < 19) ? 3 : 99;
            end
            run_cfg(1'b0);
        end
        clear_plan();

        // reset during WAIT of entry 7
        prep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (go_q.size() < 8 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("reach_e7", 32'(k < 5000), 1);
        check("pre_busy", 32'(busy), 1);
        check("pre_idx", 32'(cur_index), 7);
        #2 swt = 1'b0;
        #1;
        check("swt_go", 32'(i2c_go), 0);
        check("swt_busy", 32'(busy), 0);
        check("swt_data", {8'h0, i2c_data}, 0);
        check("swt_idx", 32'(cur_index), 0);
        check("swt_done", 32'(done), 0);
        check("swt_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        swt = 1'b1;
        stray_req = 1'b1;
        repeat (100) @(negedge clk);
        check("post_swt_go", go_q.size(), 8);
        check("post_swt_busy", 32'(busy), 0);
        run_cfg(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
